// File: rtl/ex_result_mux_pkg.sv
// Shared widths and FSM state encoding for the EX-stage result selector.
package ex_result_mux_pkg;
    localparam int DATA_BUS        = 32;
    localparam int DOUBLE_DATA_BUS = 2 * DATA_BUS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FULL = 2'd2
    } ex_state_e;
endpackage

// File: rtl/ex_result_mux_onehot_mux.sv
// One-hot AND-OR selector over N slices of W bits.
// Yields zero and a clear onehot_o flag for zero or multi-hot selects.
module ex_result_mux_onehot_mux #(
    parameter int N = 2,
    parameter int W = 32
) (
    input  logic [N-1:0]   sel_i,
    input  logic [N*W-1:0] data_i,
    output logic [W-1:0]   data_o,
    output logic           onehot_o
);
    localparam logic [N-1:0] ONE = N'(1);

    logic [W-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_i[i]) begin
                acc = acc | data_i[i*W +: W];
            end
        end
    end

    assign onehot_o = (sel_i != '0) && ((sel_i & (sel_i - ONE)) == '0);
    assign data_o   = onehot_o ? acc : '0;
endmodule

// File: rtl/ex_result_mux.sv
// EX-stage result selector and writeback register with multi-cycle unit launch/wait.
// Define EX_MUX_SEL_CHECK_EN to add the sticky sel_err_o output for bad selects.
//
// state   | meaning
// IDLE    | output register empty, ready for a new op
// WAIT    | multi-cycle op in flight on unit cur_k_q
// FULL    | result registered, out_valid_o high
module ex_result_mux
    import ex_result_mux_pkg::*;
#(
    parameter int DATA_W = DATA_BUS,
    parameter int N_SC   = 3,
    parameter int N_MC   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [N_SC+N_MC-1:0]     select_i,
    input  logic [N_SC*DATA_W-1:0]   sc_result_i,
    output logic [N_MC-1:0]          mc_start_o,
    output logic [N_MC-1:0]          mc_abort_o,
    input  logic [N_MC-1:0]          mc_done_i,
    input  logic [N_MC*2*DATA_W-1:0] mc_result_i,
    input  logic                     flush_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_W-1:0]        result_o,
    output logic [2*DATA_W-1:0]      mult_div_result_o,
    output logic                     res_wide_o,
    output logic                     stall_o
`ifdef EX_MUX_SEL_CHECK_EN
    ,
    output logic                     sel_err_o
`endif
);
    localparam int SEL_W = N_SC + N_MC;
    localparam int K_W   = (N_MC > 1) ? $clog2(N_MC) : 1;
    localparam logic [N_MC-1:0] ONE_MC = N_MC'(1);

    ex_state_e             state_q;
    logic                  out_valid_q;
    logic [DATA_W-1:0]     result_q;
    logic [2*DATA_W-1:0]   mdr_q;
    logic                  res_wide_q;
    logic [K_W-1:0]        cur_k_q;

    logic [DATA_W-1:0]     sc_data;
    logic                  sel_valid;
    logic [2*DATA_W-1:0]   mc_data;
    logic                  mc_sel_valid;
    logic [N_MC-1:0]       mc_sel_cur;
    logic [K_W-1:0]        mc_k;
    logic                  accept;
    logic                  mc_launch;
    logic                  done_hit;

    // Multi-cycle slots are zero in the data vector so a valid MC select yields 0 here.
    ex_result_mux_onehot_mux #(.N(SEL_W), .W(DATA_W)) u_sc_mux (
        .sel_i    (select_i),
        .data_i   ({{(N_MC*DATA_W){1'b0}}, sc_result_i}),
        .data_o   (sc_data),
        .onehot_o (sel_valid)
    );

    assign mc_sel_cur = ONE_MC << cur_k_q;

    ex_result_mux_onehot_mux #(.N(N_MC), .W(2*DATA_W)) u_mc_mux (
        .sel_i    (mc_sel_cur),
        .data_i   (mc_result_i),
        .data_o   (mc_data),
        .onehot_o (mc_sel_valid)
    );

    always_comb begin
        mc_k = '0;
        for (int k = 0; k < N_MC; k++) begin
            if (select_i[N_SC+k]) begin
                mc_k = K_W'(k);
            end
        end
    end

    assign in_ready_o = ~flush_i & ((state_q == ST_IDLE) | ((state_q == ST_FULL) & out_ready_i));
    assign accept     = in_valid_i & in_ready_o;
    assign mc_launch  = accept & sel_valid & (|select_i[SEL_W-1:N_SC]);
    assign done_hit   = (state_q == ST_WAIT) & mc_sel_valid & mc_done_i[cur_k_q];
    assign stall_o    = in_valid_i & ~in_ready_o;

    // Launch is gated by reset so a held request cannot fire a unit while it is reset.
    assign mc_start_o = (rst_n & mc_launch) ? (ONE_MC << mc_k) : '0;
    assign mc_abort_o = (flush_i && (state_q == ST_WAIT)) ? mc_sel_cur : '0;

    assign out_valid_o       = out_valid_q;
    assign result_o          = result_q;
    assign mult_div_result_o = mdr_q;
    assign res_wide_o        = res_wide_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            mdr_q       <= '0;
            res_wide_q  <= 1'b0;
            cur_k_q     <= '0;
        end else if (flush_i) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (done_hit) begin
                        mdr_q       <= mc_data;
                        result_q    <= '0;
                        res_wide_q  <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_FULL;
                    end
                end
                default: begin
                    if (accept && mc_launch) begin
                        cur_k_q     <= mc_k;
                        out_valid_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end else if (accept) begin
                        result_q    <= sc_data;
                        mdr_q       <= '0;
                        res_wide_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_FULL;
                    end else if ((state_q == ST_FULL) && out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef EX_MUX_SEL_CHECK_EN
    logic sel_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else if (accept && !sel_valid) begin
            sel_err_q <= 1'b1;
        end
    end

    assign sel_err_o = sel_err_q;
`endif
endmodule

// File: tb/tb_ex_result_mux.sv
// Scoreboard bench for ex_result_mux: randomized ops, emulated multi-cycle units, flush and reset.
module tb_ex_result_mux;
    localparam int DW  = 32;
    localparam int NSC = 3;
    localparam int NMC = 2;
    localparam int SW  = NSC + NMC;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [SW-1:0]      select = '0;
    logic [NSC*DW-1:0]  sc_result = '0;
    logic [NMC-1:0]     mc_start;
    logic [NMC-1:0]     mc_abort;
    logic [NMC-1:0]     mc_done = '0;
    logic [NMC*2*DW-1:0] mc_result = '0;
    logic               flush = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [DW-1:0]      result;
    logic [2*DW-1:0]    mult_div_result;
    logic               res_wide;
    logic               stall;
`ifdef EX_MUX_SEL_CHECK_EN
    logic               sel_err;
`endif

    always #5 clk = ~clk;

    ex_result_mux #(.DATA_W(DW), .N_SC(NSC), .N_MC(NMC)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid_i        (in_valid),
        .in_ready_o        (in_ready),
        .select_i          (select),
        .sc_result_i       (sc_result),
        .mc_start_o        (mc_start),
        .mc_abort_o        (mc_abort),
        .mc_done_i         (mc_done),
        .mc_result_i       (mc_result),
        .flush_i           (flush),
        .out_valid_o       (out_valid),
        .out_ready_i       (out_ready),
        .result_o          (result),
        .mult_div_result_o (mult_div_result),
        .res_wide_o        (res_wide),
        .stall_o           (stall)
`ifdef EX_MUX_SEL_CHECK_EN
        ,
        .sel_err_o         (sel_err)
`endif
    );

    typedef struct {
        logic [DW-1:0]   res;
        logic [2*DW-1:0] wide;
        logic            is_wide;
    } exp_t;

    exp_t        q[$];
    bit          inflight = 0;
    int          infl_k = 0;
    int          infl_cnt = 0;
    logic [63:0] infl_val = '0;
    bit          unit_hold = 0;
    bit          mc_fixed = 0;
    int          mc_fixed_dly = 0;
    logic [63:0] mc_fixed_val = '0;
    bit          sel_err_exp = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model and monitor: predicts from the rules, evaluated mid-cycle.
    always @(negedge clk) begin : model
        bit             exp_rdy;
        bit             acc;
        int             ones;
        int             idx;
        logic [NMC-1:0] exp_ab;
        logic [NMC-1:0] exp_st;
        exp_t           e;
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_result", result, 0);
            chk("rst_mdr", mult_div_result, 0);
            chk("rst_res_wide", res_wide, 0);
            chk("rst_mc_start", mc_start, 0);
            chk("rst_mc_abort", mc_abort, 0);
`ifdef EX_MUX_SEL_CHECK_EN
            chk("rst_sel_err", sel_err, 0);
`endif
            q.delete();
            inflight = 0;
            sel_err_exp = 0;
        end else begin
            exp_rdy = !flush && !inflight && (q.size() == 0 || out_ready);
            chk("in_ready", in_ready, exp_rdy);
            chk("stall", stall, in_valid && !exp_rdy);
            chk("out_valid", out_valid, q.size() != 0);
`ifdef EX_MUX_SEL_CHECK_EN
            chk("sel_err", sel_err, sel_err_exp);
`endif
            if (out_valid && q.size() != 0) begin
                chk("result", result, q[0].res);
                chk("mult_div_result", mult_div_result, q[0].wide);
                chk("res_wide", res_wide, q[0].is_wide);
                if (out_ready) void'(q.pop_front());
            end
            exp_ab = (flush && inflight) ? (NMC'(1) << infl_k) : '0;
            chk("mc_abort", mc_abort, exp_ab);
            acc  = in_valid && exp_rdy;
            ones = $countones(select);
            idx  = 0;
            for (int i = 0; i < SW; i++) if (select[i]) idx = i;
            exp_st = (acc && ones == 1 && idx >= NSC) ? (NMC'(1) << (idx - NSC)) : '0;
            chk("mc_start", mc_start, exp_st);
            if (flush) begin
                q.delete();
                inflight = 0;
            end else if (inflight && mc_done[infl_k]) begin
                e.res = '0; e.wide = infl_val; e.is_wide = 1'b1;
                q.push_back(e);
                inflight = 0;
            end else if (acc) begin
                if (ones != 1) sel_err_exp = 1;
                if (ones == 1 && idx >= NSC) begin
                    inflight = 1;
                    infl_k   = idx - NSC;
                    if (mc_fixed) begin
                        infl_cnt = mc_fixed_dly;
                        infl_val = mc_fixed_val;
                        mc_fixed = 0;
                    end else begin
                        infl_cnt = $urandom_range(0, 4);
                        infl_val = {$urandom, $urandom};
                    end
                end else begin
                    e.res     = (ones == 1) ? sc_result[idx*DW +: DW] : '0;
                    e.wide    = '0;
                    e.is_wide = 1'b0;
                    q.push_back(e);
                end
            end
        end
    end

    // Emulated multi-cycle units; other units' done lines toggle randomly and must be ignored.
    always @(posedge clk) begin
        logic [NMC-1:0] d;
        #1;
        d = NMC'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) d = '0;
        mc_result = {$urandom, $urandom, $urandom, $urandom};
        if (inflight) begin
            d[infl_k] = 1'b0;
            if (!unit_hold) begin
                if (infl_cnt == 0) begin
                    d[infl_k] = 1'b1;
                    mc_result[infl_k*2*DW +: 2*DW] = infl_val;
                end else begin
                    infl_cnt--;
                end
            end
        end
        mc_done = d;
    end

    task automatic drive(input bit v, input logic [SW-1:0] s, input logic [NSC*DW-1:0] sc,
                         input bit ordy, input bit fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        select    = s;
        sc_result = sc;
        out_ready = ordy;
        flush     = fl;
    endtask

    function automatic logic [SW-1:0] rand_sel();
        int r;
        r = $urandom_range(0, 99);
        if (r < 60) return SW'(1) << $urandom_range(0, SW - 1);
        else if (r < 70) return '0;
        else return SW'($urandom);
    endfunction

    initial begin
        logic [NSC*DW-1:0] scv;
        bit launched;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, '0, '0, 1, 0);

        // back-to-back single-cycle ops
        drive(1, 5'b00001, {32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'h0000_0005}, 1, 0);
        drive(1, 5'b00100, {32'hFFFF_0000, 32'h1234_5678, 32'h0000_0005}, 1, 0);
        // multi-cycle k=0 completing after four WAIT cycles, with an op stalled behind it
        mc_fixed_val = 64'h1_0000_0002; mc_fixed_dly = 3; mc_fixed = 1;
        drive(1, 5'b01000, '0, 1, 0);
        repeat (6) drive(1, 5'b00010, {32'h0, 32'h0000_0077, 32'h0}, 1, 0);
        // backpressure
        drive(1, 5'b00001, {64'h0, 32'h0000_0011}, 1, 0);
        repeat (3) drive(1, 5'b00100, {32'h0000_0022, 64'h0}, 0, 0);
        drive(1, 5'b00100, {32'h0000_0022, 64'h0}, 1, 0);
        drive(0, '0, '0, 1, 0);
        // flush in WAIT coinciding with mc_done[1]
        mc_fixed_val = 64'hDEAD_BEEF_0000_0001; mc_fixed_dly = 2; mc_fixed = 1;
        drive(1, 5'b10000, '0, 1, 0);
        drive(0, '0, '0, 1, 0);
        drive(0, '0, '0, 1, 0);
        drive(0, '0, '0, 1, 1);
        drive(0, '0, '0, 1, 0);
        // zero / non-one-hot select
        drive(1, 5'b00011, {32'h3, 32'h2, 32'h1}, 1, 0);
        drive(1, 5'b00000, {32'h3, 32'h2, 32'h1}, 1, 0);
        drive(0, '0, '0, 1, 0);

        for (int c = 0; c < 3000; c++) begin
            scv = {$urandom, $urandom, $urandom};
            drive($urandom_range(0, 9) < 7, rand_sel(), scv,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
        end
        repeat (12) drive(0, '0, '0, 1, 0);

        // reset while a multi-cycle op is in flight
        unit_hold = 1;
        launched  = 0;
        for (int t = 0; t < 20 && !launched; t++) begin
            drive(1, 5'b01000, '0, 1, 0);
            @(negedge clk);
            launched = inflight;
        end
        n_cmp++;
        if (!launched) begin
            n_bad++;
            $display("FAIL launch_timeout: got no acceptance expected acceptance within 20 cycles");
        end
        drive(1, 5'b01000, '0, 1, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        unit_hold = 0;
        repeat (4) drive(0, '0, '0, 1, 0);
        drive(1, 5'b00010, {32'h0, 32'hCAFE_F00D, 32'h0}, 1, 0);
        repeat (3) drive(0, '0, '0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ex_result_mux.md
# ex_result_mux

Parametrised execute-stage result selector and writeback register for the EX stage. It accepts one operation per handshake from ID/EX and picks a result by one-hot `select` from N_SC single-cycle units (adder, logic, HI/LO read, …) or N_MC multi-cycle units (mult, div, …). Single-cycle results are registered; for multi-cycle results it launches the unit, waits for completion and stalls upstream meanwhile. The registered result is presented to EX/MEM through a valid/ready handshake.

## Interface
- `DATA_W`, 32, width of a single-cycle result; multi-cycle results are 2*DATA_W (HI:LO)
- `N_SC`, 3, number of single-cycle sources
- `N_MC`, 2, number of multi-cycle sources
- Select width SEL_W = N_SC+N_MC; bit i < N_SC selects `sc_result` slice i; bit N_SC+k selects multi-cycle unit k

- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operation offered by ID/EX
- `in_ready`  out  1  operation accepted when `in_valid & in_ready` at a rising edge
- `select`  in  SEL_W  one-hot source select, sampled on acceptance
- `sc_result`  in  N_SC*DATA_W  single-cycle results, slice i at [i*DATA_W +: DATA_W], sampled on acceptance
- `mc_start`  out  N_MC  one-cycle launch pulse to multi-cycle unit k
- `mc_abort`  out  N_MC  one-cycle pulse cancelling the in-flight unit k
- `mc_done`  in  N_MC  unit k result valid this cycle
- `mc_result`  in  N_MC*2*DATA_W  multi-cycle results, slice k at [k*2*DATA_W +: 2*DATA_W]
- `flush`  in  1  kill pending and held operation
- `out_valid`  out  1  registered result valid
- `out_ready`  in  1  EX/MEM consumes the result
- `result`  out  DATA_W  single-cycle result
- `mult_div_result`  out  2*DATA_W  multi-cycle result
- `res_wide`  out  1  1: `mult_div_result` valid; 0: `result` valid
- `stall`  out  1  `in_valid & ~in_ready`

## Operation
- States: IDLE (output empty), WAIT (multi-cycle op in flight, unit index `cur_k` stored), FULL (`out_valid`=1).
- `in_ready` = (IDLE) | (FULL & `out_ready`); always 0 in WAIT and whenever `flush`=1.
- Acceptance, single-cycle select or zero/non-one-hot select: load `result` (0 for zero/non-one-hot), `mult_div_result`=0, `res_wide`=0 → FULL.
- Acceptance, multi-cycle bit k: pulse `mc_start[k]`, `cur_k`=k → WAIT. `mc_start` is combinational on the accepting cycle.
- WAIT & `mc_done[cur_k]`: load `mult_div_result` = slice `cur_k`, `result`=0, `res_wide`=1 → FULL. `mc_done` of any other unit is ignored in every state.
- FULL & `out_ready`: with acceptance, handled as above (back-to-back); without it → IDLE.
- `flush`: next state IDLE, `out_valid` cleared; in WAIT, `mc_abort[cur_k]` pulses in the same cycle. `flush` beats `mc_done` and acceptance in the same cycle.
- Reset: state IDLE, `out_valid`, `result`, `mult_div_result`, `res_wide`, `cur_k`=0; `mc_start`, `mc_abort`=0 while `rst_n`=0. Reset mid-WAIT does not pulse `mc_abort`; units are reset by the same `rst_n`.

## Timing
- Single-cycle latency: accepted at edge N → `out_valid` high after edge N.
- Multi-cycle: `mc_done` sampled at edge M → `out_valid` high after edge M; zero added latency on completion.
- Throughput: one single-cycle op per cycle with `out_ready` held high.
- Outputs `result`, `mult_div_result`, `res_wide`, `out_valid` are registered; they are held stable while `out_valid & ~out_ready`.

## Configuration
- `EX_MUX_SEL_CHECK_EN` defined: extra output `sel_err` (1 bit, reset 0), sticky, set when an accepted `select` is zero or not one-hot; cleared only by reset. Op still completes with `result`=0.
- Not defined: no `sel_err` port; zero/non-one-hot select silently yields `result`=0.

## Structure
- Shared package/include (`bus.v` family): `DATA_BUS`/`DOUBLE_DATA_BUS` widths and the state encoding constants (IDLE/WAIT/FULL).
- One sub-module: `onehot_mux`, parametrised combinational one-hot AND-OR selector, instantiated for the single-cycle and multi-cycle paths, with one-hot validity flag.

## Test plan
- Reset: `rst_n`=0 mid-WAIT → all outputs 0, state IDLE, `in_ready`=1 after release.
- Back-to-back single-cycle: select=5'b00001 with `sc_result[0]`=32'h0000_0005, then 5'b00100 with slice 2=32'hFFFF_0000, `out_ready`=1 → `result` 5 then FFFF_0000 on consecutive cycles, `res_wide`=0.
- Multi-cycle: select=5'b01000 (k=0), `mc_done[0]` 4 cycles later with 64'h1_0000_0002 → `mc_start[0]` one pulse, `stall`=1 for 4 cycles, `mult_div_result`=64'h1_0000_0002, `res_wide`=1.
- Backpressure: `out_ready`=0 for 3 cycles in FULL → output held, `in_ready`=0, second op accepted on the cycle `out_ready` rises.
- Flush in WAIT coinciding with `mc_done[1]` → `mc_abort[1]` pulse, no `out_valid`, state IDLE.
- Select=5'b00011 with `EX_MUX_SEL_CHECK_EN` → `result`=0, `sel_err`=1 sticky; without macro → `result`=0 only.
